// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage femtoRV32 core: turns hazard,
// branch and data-memory wait conditions into per-stage load/flush controls.
module hazard_stall_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DW-1:0]     drain_cnt_r;
    logic [WW-1:0]     wait_cnt_r;
    logic              prev_lu_r;
    logic              proto_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              mem_wait_s;
    logic              lu_fire_s;
    logic              br_fire_s;
    logic              drain_adv_s;
    logic              timeout_s;
    logic              dbl_lu_s;
    logic              pc_write_s;
    logic              if_id_write_s;
    logic              if_id_flush_s;
    logic              id_ex_write_s;
    logic              id_ex_flush_s;
    logic              ex_mem_write_s;
    logic              mem_wb_flush_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign mem_wait_s = mem_req & ~mem_ready;

    // Next-state and per-stage controls; a memory wait outranks everything, then branch, load-use, halt
    always_comb begin
        state_nxt_s    = state_r;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_write_s  = 1'b1;
        id_ex_flush_s  = 1'b0;
        ex_mem_write_s = 1'b1;
        mem_wb_flush_s = 1'b0;
        lu_fire_s      = 1'b0;
        br_fire_s      = 1'b0;
        drain_adv_s    = 1'b0;
        case (state_r)
            RUN, MEM_WAIT: begin
                if (mem_wait_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                    state_nxt_s    = MEM_WAIT;
                end else if (branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    br_fire_s     = 1'b1;
                    state_nxt_s   = RUN;
                end else if (load_use_stall) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                    lu_fire_s     = 1'b1;
                    state_nxt_s   = RUN;
                end else if (halt_req) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                    state_nxt_s   = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (mem_wait_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    br_fire_s     = 1'b1;
                    state_nxt_s   = RUN;
                end else begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                    drain_adv_s   = 1'b1;
                    if (drain_cnt_r == DW'(DRAIN_CYCLES - 1)) begin
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
            end
            HALTED: begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                id_ex_flush_s = 1'b1;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    assign timeout_s = mem_wait_s && (state_r != HALTED) && (wait_cnt_r == WW'(MEM_TIMEOUT - 1));
    assign dbl_lu_s  = lu_fire_s & prev_lu_r;

    // State, drain/wait counters and the sticky protocol flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            drain_cnt_r <= '0;
            wait_cnt_r  <= '0;
            prev_lu_r   <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            prev_lu_r   <= lu_fire_s;
            proto_err_r <= proto_err_r | timeout_s | dbl_lu_s;
            if (state_r != DRAIN) begin
                drain_cnt_r <= '0;
            end else if (drain_adv_s) begin
                drain_cnt_r <= drain_cnt_r + DW'(1);
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
            if (mem_wait_s && (state_r != HALTED)) begin
                if (wait_cnt_r != WW'(MEM_TIMEOUT)) begin
                    wait_cnt_r <= wait_cnt_r + WW'(1);
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end else begin
                wait_cnt_r <= '0;
            end
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (clr_cnt) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (!pc_write_s && (state_r != HALTED)) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (br_fire_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_write     = pc_write_s & rst_n;
    assign if_id_write  = if_id_write_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_write  = id_ex_write_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_write = ex_mem_write_s;
    assign mem_wb_flush = mem_wb_flush_s;
    assign halted       = (state_r == HALTED);
    assign proto_err    = proto_err_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use_stall, branch_taken, mem_req, mem_ready, halt_req, clr_cnt;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, mem_wb_flush, halted, proto_err;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush;
    logic        s_ex_mem_write, s_mem_wb_flush, s_halted, s_proto_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .clr_cnt(clr_cnt),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .mem_wb_flush(mem_wb_flush), .halted(halted), .proto_err(proto_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .clr_cnt(clr_cnt),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_write(s_id_ex_write), .id_ex_flush(s_id_ex_flush), .ex_mem_write(s_ex_mem_write),
        .mem_wb_flush(s_mem_wb_flush), .halted(s_halted), .proto_err(s_proto_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic idle_inputs();
        load_use_stall = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
        mem_ready = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write got=%b exp=0", pc_write); end
        checks++; if ({if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush} !== 6'b111000) begin
            errors++; $display("FAIL rst_ctrl got=%b exp=111000", {if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({pc_write, if_id_flush, id_ex_flush, mem_wb_flush} !== 4'b1000) begin
                errors++; $display("FAIL idle_ctrl cyc=%0d got=%b exp=1000", i, {pc_write, if_id_flush, id_ex_flush, mem_wb_flush}); end
            @(negedge clk);
        end
        #1;
        checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL idle_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        checks++; if ({halted, proto_err} !== 2'b00) begin errors++; $display("FAIL idle_flags got=%b exp=00", {halted, proto_err}); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_stall = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_write, id_ex_flush, id_ex_write} !== 4'b0011) begin
            errors++; $display("FAIL lu_ctrl got=%b exp=0011", {pc_write, if_id_write, id_ex_flush, id_ex_write}); end
        @(negedge clk);
        load_use_stall = 1'b0;
        #1;
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        checks++; if ({pc_write, if_id_write, id_ex_flush, proto_err} !== 4'b1100) begin
            errors++; $display("FAIL lu_resume got=%b exp=1100", {pc_write, if_id_write, id_ex_flush, proto_err}); end
    endtask

    task automatic test_lu_branch();
        do_reset();
        load_use_stall = 1'b1; branch_taken = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b111) begin
            errors++; $display("FAIL lubr_ctrl got=%b exp=111", {pc_write, if_id_flush, id_ex_flush}); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL lubr_cnts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_flush, if_id_flush, id_ex_flush} !== 7'b0000100) begin
                errors++; $display("FAIL mw_freeze cyc=%0d got=%b exp=0000100", i,
                    {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_flush, if_id_flush, id_ex_flush}); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_flush, id_ex_flush, mem_wb_flush} !== 4'b1110) begin
            errors++; $display("FAIL mw_release got=%b exp=1110", {pc_write, if_id_flush, id_ex_flush, mem_wb_flush}); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (stall_cnt !== 16'd4 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL mw_cnts got=%0d/%0d exp=4/1", stall_cnt, flush_cnt); end
        checks++; if (if_id_flush !== 1'b0) begin errors++; $display("FAIL mw_single_flush got=%b exp=0", if_id_flush); end
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL halt_req_ctrl got=%b exp=001", {pc_write, if_id_write, id_ex_flush}); end
        @(negedge clk);
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({halted, pc_write, if_id_write, id_ex_flush, ex_mem_write} !== 5'b00011) begin
                errors++; $display("FAIL drain cyc=%0d got=%b exp=00011", i, {halted, pc_write, if_id_write, id_ex_flush, ex_mem_write}); end
            @(negedge clk);
        end
        #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_rise got=%b exp=1", halted); end
        load_use_stall = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({halted, pc_write, if_id_flush, id_ex_flush, mem_wb_flush} !== 5'b10010) begin
            errors++; $display("FAIL halted_ignore got=%b exp=10010", {halted, pc_write, if_id_flush, id_ex_flush, mem_wb_flush}); end
        checks++; if (stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL halted_cnts got=%0d/%0d exp=4/0", stall_cnt, flush_cnt); end
        do_reset();
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        @(negedge clk);
        branch_taken = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_flush, id_ex_flush} !== 3'b111) begin
            errors++; $display("FAIL drain_cancel got=%b exp=111", {pc_write, if_id_flush, id_ex_flush}); end
        @(negedge clk);
        branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({halted, pc_write, if_id_write} !== 3'b011) begin
            errors++; $display("FAIL drain_back_run got=%b exp=011", {halted, pc_write, if_id_write}); end
        checks++; if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL cancel_cnts got=%0d/%0d exp=2/1", stall_cnt, flush_cnt); end
    endtask

    task automatic test_back_to_back_lu();
        do_reset();
        load_use_stall = 1'b1;
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b exp=0", proto_err); end
        @(negedge clk);
        #1;
        checks++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b001) begin
            errors++; $display("FAIL b2b_rule3 got=%b exp=001", {pc_write, if_id_write, id_ex_flush}); end
        @(negedge clk);
        load_use_stall = 1'b0;
        #1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL b2b_set got=%b exp=1", proto_err); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL b2b_sticky got=%b exp=1", proto_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_reset got=%b exp=0", proto_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (63) @(negedge clk);
        #1;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", proto_err); end
        @(negedge clk);
        #1;
        checks++; if ({proto_err, mem_wb_flush, pc_write} !== 3'b110) begin
            errors++; $display("FAIL to_set got=%b exp=110", {proto_err, mem_wb_flush, pc_write}); end
        mem_ready = 1'b1;
        #1;
        checks++; if ({pc_write, mem_wb_flush} !== 2'b10) begin
            errors++; $display("FAIL to_release got=%b exp=10", {pc_write, mem_wb_flush}); end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++; if (s_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
        clr_cnt = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
            errors++; $display("FAIL clr_prio got=%0d/%0d exp=0/0", stall_cnt, s_stall_cnt); end
        clr_cnt = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL clr_resume got=%0d exp=1", stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_branch();
        test_mem_wait();
        test_halt();
        test_back_to_back_lu();
        test_timeout();
        test_saturate_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
